// File: rtl/hs_bus_amba_axis_if.sv
// AXI-Stream bundle: handshake, full payload and twakeup, with master/slave views.
interface hs_bus_amba_axis_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TSTRB_WIDTH-1:0] tstrb;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   twakeup;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    output tready
  );
endinterface

// File: rtl/hs_bus_amba_axis_reg_slice.sv
// AXI-Stream register slice: two-entry skid buffer with every output from a flop,
// plus occupancy and completed-packet status.
//
// state    | meaning
// ST_EMPTY | no stored beat
// ST_ONE   | OUT holds a beat
// ST_FULL  | OUT and SKD both hold a beat
module hs_bus_amba_axis_reg_slice #(
  parameter int TDATA_WIDTH   = 8,
  parameter int TID_WIDTH     = 1,
  parameter int TDEST_WIDTH   = 1,
  parameter int TUSER_WIDTH   = 1,
  parameter int TSTRB_WIDTH   = TDATA_WIDTH / 8,
  parameter int TKEEP_WIDTH   = TDATA_WIDTH / 8,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hs_bus_amba_axis_if.slave        s_axis_if,
  hs_bus_amba_axis_if.master       m_axis_if,
  output logic [1:0]               occupancy,
  output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);
  localparam int BEAT_W   = TDATA_WIDTH + TSTRB_WIDTH + TKEEP_WIDTH + 1
                            + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
  localparam int LAST_POS = TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [BEAT_W-1:0]        r_out;
  logic [BEAT_W-1:0]        r_skd;
  logic [BEAT_W-1:0]        w_s_beat;
  logic                     r_m_tvalid;
  logic                     r_s_tready;
  logic                     r_m_twakeup;
  logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;
  logic                     w_s_hs;
  logic                     w_m_hs;
  logic                     w_load_out_in;
  logic                     w_load_out_skd;
  logic                     w_load_skd;

  assign w_s_beat = {s_axis_if.tdata, s_axis_if.tstrb, s_axis_if.tkeep, s_axis_if.tlast,
                     s_axis_if.tid, s_axis_if.tdest, s_axis_if.tuser};

  assign w_s_hs = s_axis_if.tvalid & r_s_tready;
  assign w_m_hs = r_m_tvalid & m_axis_if.tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_load_out_in  = 1'b0;
    w_load_out_skd = 1'b0;
    w_load_skd     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_s_hs) begin
          w_load_out_in = 1'b1;
          w_next_state  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_s_hs && w_m_hs) begin
          w_load_out_in = 1'b1;
        end else if (w_s_hs) begin
          w_load_skd   = 1'b1;
          w_next_state = ST_FULL;
        end else if (w_m_hs) begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // tready is low here, so only the downstream side can move
        if (w_m_hs) begin
          w_load_out_skd = 1'b1;
          w_next_state   = ST_ONE;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_skd       <= '0;
      r_m_tvalid  <= 1'b0;
      r_s_tready  <= 1'b0;
      r_m_twakeup <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_m_tvalid  <= (w_next_state != ST_EMPTY);
      r_s_tready  <= (w_next_state != ST_FULL);
      r_m_twakeup <= s_axis_if.twakeup | s_axis_if.tvalid | (r_state != ST_EMPTY);
      if (w_load_out_in) begin
        r_out <= w_s_beat;
      end else if (w_load_out_skd) begin
        r_out <= r_skd;
      end
      if (w_load_skd) begin
        r_skd <= w_s_beat;
      end
      if (w_m_hs && r_out[LAST_POS]) begin
        r_pkt_cnt <= r_pkt_cnt + PKT_CNT_WIDTH'(1);
      end
    end
  end

  assign s_axis_if.tready  = r_s_tready;
  assign m_axis_if.tvalid  = r_m_tvalid;
  assign m_axis_if.twakeup = r_m_twakeup;
  assign {m_axis_if.tdata, m_axis_if.tstrb, m_axis_if.tkeep, m_axis_if.tlast,
          m_axis_if.tid, m_axis_if.tdest, m_axis_if.tuser} = r_out;

  assign occupancy = r_state;
  assign pkt_cnt   = r_pkt_cnt;
endmodule

// File: tb/tb_hs_bus_amba_axis_reg_slice.sv
// Bench for the AXIS register slice: random/directed stimulus, queue-based reference
// model and a scoreboard monitor; a second instance uses a 2-bit packet counter.
module tb_hs_bus_amba_axis_reg_slice;
  typedef struct packed {
    logic [7:0] tdata;
    logic       tstrb;
    logic       tkeep;
    logic       tlast;
    logic       tid;
    logic       tdest;
    logic       tuser;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hs_bus_amba_axis_if #(.TDATA_WIDTH(8)) s_if ();
  hs_bus_amba_axis_if #(.TDATA_WIDTH(8)) m_if ();
  hs_bus_amba_axis_if #(.TDATA_WIDTH(8)) s2_if ();
  hs_bus_amba_axis_if #(.TDATA_WIDTH(8)) m2_if ();

  logic [1:0]  occ;
  logic [1:0]  occ2;
  logic [15:0] pkt_cnt;
  logic [1:0]  pkt_cnt2;

  hs_bus_amba_axis_reg_slice #(.TDATA_WIDTH(8), .PKT_CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .s_axis_if(s_if), .m_axis_if(m_if),
    .occupancy(occ), .pkt_cnt(pkt_cnt)
  );

  hs_bus_amba_axis_reg_slice #(.TDATA_WIDTH(8), .PKT_CNT_WIDTH(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .s_axis_if(s2_if), .m_axis_if(m2_if),
    .occupancy(occ2), .pkt_cnt(pkt_cnt2)
  );

  assign s2_if.tvalid  = s_if.tvalid;
  assign s2_if.tdata   = s_if.tdata;
  assign s2_if.tstrb   = s_if.tstrb;
  assign s2_if.tkeep   = s_if.tkeep;
  assign s2_if.tlast   = s_if.tlast;
  assign s2_if.tid     = s_if.tid;
  assign s2_if.tdest   = s_if.tdest;
  assign s2_if.tuser   = s_if.tuser;
  assign s2_if.twakeup = s_if.twakeup;
  assign m2_if.tready  = m_if.tready;

  int total = 0;
  int bad   = 0;

  beat_t stim_q[$];
  beat_t exp_q[$];
  int    v_pct = 100;
  int    r_pct = 100;
  int    wk_pct = 0;
  logic  wake_force = 1'b0;
  logic  acc_flag = 1'b0;
  logic  have = 1'b0;
  beat_t cur = '0;

  logic        mon_en = 1'b0;
  logic        after_rst = 1'b1;
  logic        exp_wake = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic        prev_stall = 1'b0;
  beat_t       prev_beat = '0;
  int          m_hs_cnt = 0;
  int          max_occ = 0;
  int          cyc = 0;
  int          first_m_cyc = -1;
  int          last_m_cyc = -1;
  int          first_s_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t get_m();
    return {m_if.tdata, m_if.tstrb, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};
  endfunction

  function automatic beat_t get_s();
    return {s_if.tdata, s_if.tstrb, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser};
  endfunction

  function automatic beat_t mk(input logic [7:0] d, input logic last);
    beat_t b;
    b = '0;
    b.tdata = d;
    b.tstrb = 1'b1;
    b.tkeep = 1'b1;
    b.tlast = last;
    return b;
  endfunction

  // driver: holds a presented beat until the monitor reports it was accepted
  always @(posedge clk) begin
    #2;
    if (rst) begin
      have = 1'b0;
      s_if.tvalid = 1'b0;
    end else begin
      if (have && acc_flag) have = 1'b0;
      if (!have && stim_q.size() != 0 && int'($urandom_range(99)) < v_pct) begin
        cur  = stim_q.pop_front();
        have = 1'b1;
      end
      s_if.tvalid = have;
      {s_if.tdata, s_if.tstrb, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser} = cur;
    end
    m_if.tready  = (int'($urandom_range(99)) < r_pct);
    s_if.twakeup = wake_force | (int'($urandom_range(99)) < wk_pct);
  end

  // monitor: reference model is a FIFO of accepted beats plus a packet count
  always @(negedge clk) begin
    if (mon_en) begin
      int    n;
      beat_t mb;
      beat_t eb;
      logic  shs;
      logic  mhs;
      cyc++;
      n  = exp_q.size();
      mb = get_m();
      chk("occupancy", {30'd0, occ}, n);
      chk("m_tvalid", {31'd0, m_if.tvalid}, {31'd0, n != 0});
      chk("s_tready", {31'd0, s_if.tready}, after_rst ? 32'd0 : {31'd0, n < 2});
      chk("m_twakeup", {31'd0, m_if.twakeup}, {31'd0, exp_wake});
      chk("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, exp_cnt});
      chk("pkt_cnt_w2", {30'd0, pkt_cnt2}, {30'd0, exp_cnt[1:0]});
      chk("w2_tvalid", {31'd0, m2_if.tvalid}, {31'd0, n != 0});
      if (prev_stall) chk("hold_payload", {18'd0, mb}, {18'd0, prev_beat});
      if (n > max_occ) max_occ = n;
      shs = s_if.tvalid & s_if.tready;
      mhs = m_if.tvalid & m_if.tready;
      exp_wake = rst ? 1'b0 : (s_if.twakeup | s_if.tvalid | (n != 0));
      if (rst) begin
        exp_q.delete();
        exp_cnt    = '0;
        after_rst  = 1'b1;
        prev_stall = 1'b0;
        acc_flag   = 1'b0;
      end else begin
        after_rst = 1'b0;
        if (mhs && n != 0) begin
          eb = exp_q.pop_front();
          chk("payload", {18'd0, mb}, {18'd0, eb});
          if (eb.tlast) exp_cnt = exp_cnt + 16'd1;
          m_hs_cnt++;
          if (first_m_cyc < 0) first_m_cyc = cyc;
          last_m_cyc = cyc;
        end
        if (shs) begin
          exp_q.push_back(get_s());
          if (first_s_cyc < 0) first_s_cyc = cyc;
        end
        acc_flag   = shs;
        prev_stall = m_if.tvalid & ~m_if.tready;
        prev_beat  = mb;
      end
    end
  end

  task automatic drain(input int budget, input string name);
    int c;
    c = 0;
    while ((stim_q.size() != 0 || have || exp_q.size() != 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk({"drain_", name}, {31'd0, c < budget}, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    stim_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int start;
    int c;
    s_if.tvalid = 1'b0;
    s_if.twakeup = 1'b0;
    {s_if.tdata, s_if.tstrb, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser} = '0;
    m_if.tready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
    chk("rst_m_twakeup", {31'd0, m_if.twakeup}, 32'd0);
    chk("rst_payload", {18'd0, get_m()}, 32'd0);
    chk("rst_occupancy", {30'd0, occ}, 32'd0);
    chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_rst", {31'd0, s_if.tready}, 32'd1);

    // streaming
    r_pct = 100; v_pct = 100; max_occ = 0;
    first_m_cyc = -1; first_s_cyc = -1;
    start = m_hs_cnt;
    for (int i = 0; i < 8; i++) stim_q.push_back(mk(8'(i), i == 7));
    drain(100, "stream");
    chk("stream_beats", m_hs_cnt - start, 8);
    chk("stream_max_occ", max_occ, 1);
    chk("stream_latency", first_m_cyc - first_s_cyc, 1);
    chk("stream_span", last_m_cyc - first_m_cyc, 7);
    chk("stream_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

    // stall / skid
    r_pct = 0;
    start = m_hs_cnt;
    stim_q.push_back(mk(8'h10, 1'b0));
    stim_q.push_back(mk(8'h11, 1'b0));
    stim_q.push_back(mk(8'h12, 1'b1));
    repeat (8) @(negedge clk);
    chk("stall_occupancy", {30'd0, occ}, 32'd2);
    chk("stall_s_tready", {31'd0, s_if.tready}, 32'd0);
    chk("stall_m_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    chk("stall_m_tdata", {24'd0, m_if.tdata}, 32'h10);
    r_pct = 100;
    drain(100, "stall");
    chk("stall_beats", m_hs_cnt - start, 3);
    chk("stall_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);

    // random protocol
    v_pct = 50; r_pct = 50; wk_pct = 10;
    start = m_hs_cnt;
    for (int i = 0; i < 10000; i++) stim_q.push_back(beat_t'($urandom));
    drain(60000, "random");
    chk("random_beats", m_hs_cnt - start, 10000);
    wk_pct = 0;

    // reset mid-operation
    v_pct = 100; r_pct = 0;
    for (int i = 0; i < 3; i++) stim_q.push_back(mk(8'h30 + 8'(i), 1'b1));
    c = 0;
    while (occ != 2'd2 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("midrst_full", {30'd0, occ}, 32'd2);
    pulse_reset();
    @(negedge clk);
    chk("midrst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("midrst_s_tready", {31'd0, s_if.tready}, 32'd0);
    chk("midrst_occupancy", {30'd0, occ}, 32'd0);
    chk("midrst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    r_pct = 100;
    start = m_hs_cnt;
    stim_q.push_back(mk(8'hA5, 1'b1));
    drain(100, "midrst");
    chk("midrst_beats", m_hs_cnt - start, 1);
    chk("midrst_pkt_after", {16'd0, pkt_cnt}, 32'd1);

    // wakeup
    repeat (3) @(posedge clk);
    #1;
    wake_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wake_high", {31'd0, m_if.twakeup}, 32'd1);
    chk("wake_no_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    wake_force = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("wake_low", {31'd0, m_if.twakeup}, 32'd0);

    // 2-bit counter wrap: five single-beat packets from reset
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      stim_q.push_back(mk(8'h50 + 8'(i), 1'b1));
      drain(100, "wrap");
      @(negedge clk);
      chk("wrap_seq", {30'd0, pkt_cnt2}, (i + 1) % 4);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
